// File: rtl/mac128_seq.sv
// Sequential unsigned multiply-accumulate: shift-add multiply, one multiplier bit per cycle,
// followed by a single-cycle add into a wide accumulator with a sticky carry-out flag.
module mac128_seq #(
  parameter int unsigned W     = 64,
  parameter int unsigned ACC_W = 128  // must equal 2*W so the product is never truncated
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StBusy, StAccum, StDone} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]      mplier_q, mplier_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ACC_W-1:0]  prod_q, prod_d;
  logic              clr_q, clr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W:0]    sum;

  assign sum = {1'b0, acc_q} + {1'b0, prod_q};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    prod_d   = prod_q;
    clr_d    = clr_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = ACC_W'(a);
          mplier_d = b;
          clr_d    = acc_clr;
          prod_d   = '0;
          count_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // mcand_q holds a<<count and mplier_q[0] holds b[count]
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        if (count_q == CntW'(W - 1)) begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (clr_q) begin
          acc_d = prod_q;
          ovf_d = 1'b0;
        end else begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      prod_q   <= '0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      clr_q    <= clr_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac128_seq.sv
// Self-checking bench for mac128_seq: directed cases plus randomized operations compared
// against an arithmetic model of the accumulator.
module tb_mac128_seq;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] acc;
  logic         ovf;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [127:0] m_acc    = '0;
  logic         m_ovf    = 1'b0;

  mac128_seq #(
    .W     (64),
    .ACC_W (128)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full operation: accept, wait for result, compare with model, optional backpressure.
  task automatic do_op(input logic [63:0] op_a, input logic [63:0] op_b, input logic clr,
                       input int hold, input bit noisy);
    logic [127:0] prod;
    logic [128:0] sum;
    logic [127:0] held;
    int           edges;
    @(negedge clk);
    check("in_ready_idle", 128'(in_ready), 128'd1);
    a        = op_a;
    b        = op_b;
    acc_clr  = clr;
    in_valid = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 200) begin
      if (noisy) begin
        in_valid  = 1'($urandom);
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
        acc_clr   = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 128'(edges), 128'd65);

    prod = 128'(op_a) * 128'(op_b);
    if (clr) begin
      m_acc = prod;
      m_ovf = 1'b0;
    end else begin
      sum   = {1'b0, m_acc} + {1'b0, prod};
      m_acc = sum[127:0];
      m_ovf = m_ovf | sum[128];
    end
    check("acc", acc, m_acc);
    check("ovf", 128'(ovf), 128'(m_ovf));
    check("in_ready_done", 128'(in_ready), 128'd0);

    held = acc;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_acc", acc, held);
      check("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 128'(out_valid), 128'd0);
    check("release_in_ready", 128'(in_ready), 128'd1);
    check("release_acc", acc, m_acc);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b0;

    #3;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_acc", acc, 128'd0);
    check("rst_ovf", 128'(ovf), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_in_ready", 128'(in_ready), 128'd1);
    check("rst_hold_acc", acc, 128'd0);
    reset_n = 1'b1;

    // Basic MAC
    do_op(64'd3, 64'd5, 1'b1, 0, 1'b0);
    check("basic_15", acc, 128'd15);
    do_op(64'd7, 64'd6, 1'b0, 0, 1'b0);
    check("basic_57", acc, 128'd57);

    // Overflow wrap
    do_op('1, '1, 1'b1, 0, 1'b0);
    check("ovf_sq", acc, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
    do_op('1, '1, 1'b0, 0, 1'b0);
    check("ovf_wrap", acc, {64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0002});
    check("ovf_set", 128'(ovf), 128'd1);
    do_op(64'd1, 64'd1, 1'b1, 0, 1'b0);
    check("ovf_clr_acc", acc, 128'd1);
    check("ovf_clr_flag", 128'(ovf), 128'd0);

    // Backpressure, then ignored inputs during BUSY
    do_op(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1'b0, 20, 1'b0);
    do_op(64'd0, '1, 1'b0, 0, 1'b1);

    // Reset asynchronously mid-operation at count=30
    @(negedge clk);
    a        = 64'd9;
    b        = 64'd9;
    acc_clr  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_acc", acc, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_ovf", 128'(ovf), 128'd0);
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_op(64'd2, 64'd2, 1'b0, 0, 1'b0);
    check("after_rst_4", acc, 128'd4);

    // Randomized operations
    for (int n = 0; n < 12; n++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
